// File: rtl/vc_output_scheduler_if.sv
// ---------------------------------------------------------------------------
// vc_output_scheduler_if
// Bundles the five upstream VC buffer read ports and the downstream FIFO
// write port of one router input port's output scheduler.
//
// Signals:
//   vc_empty[4:0]   buffer empty flags, bit0=N, bit1=S, bit2=E, bit3=W, bit4=L
//   vc_data_N..L    buffer read data, valid the cycle after the matching read_en
//   read_en[4:0]    one-hot, single-cycle pop strobe (same bit order)
//   out_full        downstream FIFO cannot accept a write this cycle
//   out_write       downstream write strobe
//   data_out        flit presented to the downstream FIFO
//   grant_vc        VC being served (N=0,S=1,E=2,W=3,L=4), 3'b111 when idle
//
// Handshake semantics:
//   Upstream: vc_empty[i]==0 acts as "valid" for VC i. A pop is requested by
//   a one-cycle pulse on read_en[i]; the buffer pops at the end of that cycle
//   and drives the popped flit on vc_data_<i> during the next cycle.
//   Downstream: out_full==0 acts as "ready". A flit transfers in exactly the
//   cycles where out_write==1, and out_write is only raised when out_full==0.
//   data_out is held stable while out_full stalls the transfer.
//
// Modports: master = scheduler side, slave = buffers/FIFO side.
// ---------------------------------------------------------------------------
interface vc_output_scheduler_if #(
  parameter int MSB_SLOT = 5,
  parameter int DSIZE    = 1 << MSB_SLOT
);
  logic [4:0]       vc_empty;
  logic [DSIZE-1:0] vc_data_N;
  logic [DSIZE-1:0] vc_data_S;
  logic [DSIZE-1:0] vc_data_E;
  logic [DSIZE-1:0] vc_data_W;
  logic [DSIZE-1:0] vc_data_L;
  logic [4:0]       read_en;
  logic             out_full;
  logic             out_write;
  logic [DSIZE-1:0] data_out;
  logic [2:0]       grant_vc;

  modport master (
    input  vc_empty, vc_data_N, vc_data_S, vc_data_E, vc_data_W, vc_data_L,
    input  out_full,
    output read_en, out_write, data_out, grant_vc
  );

  modport slave (
    output vc_empty, vc_data_N, vc_data_S, vc_data_E, vc_data_W, vc_data_L,
    output out_full,
    input  read_en, out_write, data_out, grant_vc
  );
endinterface

// File: rtl/vc_output_scheduler.sv
// ---------------------------------------------------------------------------
// vc_output_scheduler
// Round-robin scheduler between the five per-direction VC buffers of one
// router input port and the downstream switch FIFO. Each grant moves exactly
// one flit: IDLE (arbitrate) -> READ (pop strobe) -> LATCH (capture data)
// -> SEND (write when downstream not full) -> IDLE.
//
// Ports:
//   clk          system clock, all state on rising edge
//   reset        synchronous, active-high
//   bus          vc_output_scheduler_if.master (buffers + downstream FIFO)
//   dbg_state_o  current FSM state (IDLE=0, READ=1, LATCH=2, SEND=3)
// ---------------------------------------------------------------------------
module vc_output_scheduler #(
  parameter int MSB_SLOT = 5,
  localparam int DSIZE   = 1 << MSB_SLOT
) (
  input  logic                  clk,
  input  logic                  reset,
  vc_output_scheduler_if.master bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_LATCH = 2'd2,
    S_SEND  = 2'd3
  } state_t;

  localparam logic [2:0] GRANT_NONE = 3'b111;

  state_t           state_q;
  logic [2:0]       ptr_q;      // VC searched first at the next arbitration
  logic [2:0]       grant_q;
  logic [4:0]       read_en_q;
  logic [DSIZE-1:0] data_q;

  logic [4:0]       req_d;
  logic             win_valid_d;
  logic [2:0]       win_vc_d;
  logic [2:0]       ptr_d;
  logic [DSIZE-1:0] latch_data_d;

  assign req_d = ~bus.vc_empty;

  // Rotating priority: scan ptr, ptr+1, ... modulo 5 and keep the first hit.
  always_comb begin
    logic [3:0] cand;
    win_valid_d = 1'b0;
    win_vc_d    = 3'd0;
    cand        = 4'd0;
    for (int i = 0; i < 5; i++) begin
      cand = {1'b0, ptr_q} + 4'(i);
      if (cand >= 4'd5) cand = cand - 4'd5;
      if (!win_valid_d && req_d[cand[2:0]]) begin
        win_valid_d = 1'b1;
        win_vc_d    = cand[2:0];
      end
    end
  end

  // The served VC's successor becomes the highest priority next round,
  // which bounds the wait of any steadily requesting VC to four grants.
  always_comb begin
    ptr_d = (grant_q >= 3'd4) ? 3'd0 : grant_q + 3'd1;
  end

  always_comb begin
    latch_data_d = bus.vc_data_L;
    case (grant_q)
      3'd0:    latch_data_d = bus.vc_data_N;
      3'd1:    latch_data_d = bus.vc_data_S;
      3'd2:    latch_data_d = bus.vc_data_E;
      3'd3:    latch_data_d = bus.vc_data_W;
      default: latch_data_d = bus.vc_data_L;
    endcase
  end

  // vc_empty is only consulted in IDLE, so a VC that drains after being
  // granted still gets its single pop and its flit delivered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'd0;
      grant_q   <= GRANT_NONE;
      read_en_q <= 5'b0;
      data_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (win_valid_d) begin
            grant_q   <= win_vc_d;
            read_en_q <= 5'b00001 << win_vc_d;
            state_q   <= S_READ;
          end
        end
        S_READ: begin
          read_en_q <= 5'b0;
          state_q   <= S_LATCH;
        end
        S_LATCH: begin
          data_q  <= latch_data_d;
          state_q <= S_SEND;
        end
        S_SEND: begin
          if (!bus.out_full) begin
            ptr_q   <= ptr_d;
            grant_q <= GRANT_NONE;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.read_en   = read_en_q;
  assign bus.grant_vc  = grant_q;
  assign bus.data_out  = data_q;
  assign bus.out_write = (state_q == S_SEND) && !bus.out_full;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_vc_output_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vc_output_scheduler
// Drives the scheduler from five behavioural VC buffers (queues) and checks
// grants, pop strobes, delivered flits and timing against expectations
// derived from the round-robin / latency rules of the block.
// ---------------------------------------------------------------------------
module tb_vc_output_scheduler;

  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  vc_output_scheduler_if bus ();

  vc_output_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  // buffer models and sampled outputs
  logic [31:0] bq [5][$];
  logic [31:0] vdata [5];
  logic [4:0]  force_empty;
  logic [4:0]  cur_empty;
  logic        full_next;
  logic [4:0]  last_rd;
  logic [4:0]  s_rd;
  logic        s_wr;
  logic [31:0] s_do;
  logic [2:0]  s_gv;
  int          cyc;
  int          checks;
  int          failures;

  function automatic int arb(input logic [4:0] req, input int ptr);
    for (int k = 0; k < 5; k++)
      if (req[(ptr + k) % 5]) return (ptr + k) % 5;
    return 0;
  endfunction

  // One clock cycle: buffers pop on the edge that ends a read_en cycle and
  // present the popped flit during the next cycle; new inputs are applied
  // just after the edge and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    for (int v = 0; v < 5; v++)
      if (last_rd[v] && bq[v].size() > 0) vdata[v] = bq[v].pop_front();
    #1;
    for (int v = 0; v < 5; v++)
      cur_empty[v] = (bq[v].size() == 0) || force_empty[v];
    bus.vc_empty  = cur_empty;
    bus.out_full  = full_next;
    bus.vc_data_N = vdata[0];
    bus.vc_data_S = vdata[1];
    bus.vc_data_E = vdata[2];
    bus.vc_data_W = vdata[3];
    bus.vc_data_L = vdata[4];
    @(negedge clk);
    s_rd    = bus.read_en;
    s_wr    = bus.out_write;
    s_do    = bus.data_out;
    s_gv    = bus.grant_vc;
    last_rd = s_rd;
    cyc++;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    force_empty = 5'b0;
    full_next   = 1'b0;
    for (int v = 0; v < 5; v++) begin
      bq[v].delete();
      vdata[v] = 32'h0;
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_rd !== 5'b0) begin failures++; $display("FAIL reset_read_en: got %b expected %b", s_rd, 5'b0); end
    checks++; if (s_wr !== 1'b0) begin failures++; $display("FAIL reset_out_write: got %b expected 0", s_wr); end
    checks++; if (s_do !== 32'h0) begin failures++; $display("FAIL reset_data_out: got %h expected 0", s_do); end
    checks++; if (s_gv !== 3'b111) begin failures++; $display("FAIL reset_grant_vc: got %b expected 111", s_gv); end
    tick();
    checks++; if (s_rd !== 5'b0) begin failures++; $display("FAIL idle_read_en: got %b expected 0", s_rd); end
    checks++; if (s_gv !== 3'b111) begin failures++; $display("FAIL idle_grant_vc: got %b expected 111", s_gv); end
  endtask

  task automatic test_single_n();
    bq[0].push_back(32'hA5A5_0001);
    tick(); // cycle 0
    checks++; if (s_rd !== 5'b0) begin failures++; $display("FAIL single_c0_read_en: got %b expected 0", s_rd); end
    tick(); // cycle 1
    checks++; if (s_rd !== 5'b00001) begin failures++; $display("FAIL single_c1_read_en: got %b expected 00001", s_rd); end
    checks++; if (s_gv !== 3'b000) begin failures++; $display("FAIL single_c1_grant: got %b expected 000", s_gv); end
    tick(); // cycle 2
    checks++; if (s_rd !== 5'b0 || s_wr !== 1'b0) begin failures++; $display("FAIL single_c2_quiet: got rd=%b wr=%b expected rd=0 wr=0", s_rd, s_wr); end
    checks++; if (s_gv !== 3'b000) begin failures++; $display("FAIL single_c2_grant: got %b expected 000", s_gv); end
    tick(); // cycle 3
    checks++; if (s_wr !== 1'b1) begin failures++; $display("FAIL single_c3_write: got %b expected 1", s_wr); end
    checks++; if (s_do !== 32'hA5A5_0001) begin failures++; $display("FAIL single_c3_data: got %h expected a5a50001", s_do); end
    checks++; if (s_gv !== 3'b000) begin failures++; $display("FAIL single_c3_grant: got %b expected 000", s_gv); end
    tick(); // cycle 4
    checks++; if (s_gv !== 3'b111 || s_wr !== 1'b0 || s_rd !== 5'b0) begin failures++; $display("FAIL single_c4_idle: got gv=%b wr=%b rd=%b expected gv=111 wr=0 rd=0", s_gv, s_wr, s_rd); end
  endtask

  // Pointer sits at S after the N transfer: E, L, E expected.
  task automatic test_two_vc();
    logic [4:0]  exp_oh [3];
    logic [2:0]  exp_gv [3];
    logic [31:0] exp_d  [3];
    int n;
    exp_d[0] = $urandom(); exp_d[1] = $urandom(); exp_d[2] = $urandom();
    exp_oh[0] = 5'b00100; exp_oh[1] = 5'b10000; exp_oh[2] = 5'b00100;
    exp_gv[0] = 3'd2;     exp_gv[1] = 3'd4;     exp_gv[2] = 3'd2;
    bq[2].push_back(exp_d[0]);
    bq[4].push_back(exp_d[1]);
    bq[2].push_back(exp_d[2]);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin tick(); n++; end while (s_rd == 5'b0 && n < 12);
      checks++; if (s_rd !== exp_oh[k]) begin failures++; $display("FAIL two_vc_grant%0d: got %b expected %b", k, s_rd, exp_oh[k]); end
      checks++; if (s_gv !== exp_gv[k]) begin failures++; $display("FAIL two_vc_code%0d: got %b expected %b", k, s_gv, exp_gv[k]); end
      tick();
      tick();
      checks++; if (s_wr !== 1'b1 || s_do !== exp_d[k]) begin failures++; $display("FAIL two_vc_data%0d: got wr=%b data=%h expected wr=1 data=%h", k, s_wr, s_do, exp_d[k]); end
    end
    tick();
  endtask

  // Pointer sits at W here; without a pointer reset L would win again.
  task automatic test_reset_in_read();
    int n;
    bq[4].push_back(32'h1111_4444);
    n = 0;
    do begin tick(); n++; end while (s_rd == 5'b0 && n < 12);
    checks++; if (s_rd !== 5'b10000) begin failures++; $display("FAIL rst_read_grant: got %b expected 10000", s_rd); end
    reset = 1'b1;
    for (int v = 0; v < 5; v++) bq[v].delete();
    tick();
    reset = 1'b0;
    checks++; if (s_rd !== 5'b0 || s_wr !== 1'b0 || s_gv !== 3'b111) begin failures++; $display("FAIL rst_read_abort: got rd=%b wr=%b gv=%b expected rd=0 wr=0 gv=111", s_rd, s_wr, s_gv); end
    bq[4].push_back(32'h2222_4444);
    bq[0].push_back(32'h2222_0000);
    n = 0;
    do begin tick(); n++; end while (s_rd == 5'b0 && n < 12);
    checks++; if (s_rd !== 5'b00001) begin failures++; $display("FAIL rst_read_restart_n: got %b expected 00001", s_rd); end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_all_five();
    logic [31:0] pushed [5][3];
    int order [6];
    int g, wcount, last_wr, exp_vc;
    do_reset();
    for (int v = 0; v < 5; v++)
      for (int j = 0; j < 3; j++) begin
        pushed[v][j] = {8'(v), 24'($urandom())};
        bq[v].push_back(pushed[v][j]);
      end
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 4; order[5] = 0;
    g = 0; wcount = 0; last_wr = -1;
    for (int c = 0; c < 40 && wcount < 6; c++) begin
      tick();
      checks++; if ($countones(s_rd) > 1) begin failures++; $display("FAIL all5_onehot: got %b expected at most one bit", s_rd); end
      if (s_rd != 5'b0 && g < 6) begin
        checks++; if (s_rd !== (5'b00001 << order[g])) begin failures++; $display("FAIL all5_grant%0d: got %b expected %b", g, s_rd, 5'b00001 << order[g]); end
        g++;
      end
      if (s_wr) begin
        exp_vc = order[wcount];
        checks++; if (s_do !== pushed[exp_vc][wcount / 5]) begin failures++; $display("FAIL all5_data%0d: got %h expected %h", wcount, s_do, pushed[exp_vc][wcount / 5]); end
        if (last_wr >= 0) begin
          checks++; if (c - last_wr !== 4) begin failures++; $display("FAIL all5_spacing%0d: got %0d expected 4", wcount, c - last_wr); end
        end
        last_wr = c;
        wcount++;
      end
    end
    checks++; if (wcount !== 6) begin failures++; $display("FAIL all5_write_count: got %0d expected 6", wcount); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0, d1;
    do_reset();
    d0 = $urandom(); d1 = $urandom();
    bq[0].push_back(d0);
    bq[0].push_back(d1);
    for (int c = 0; c < 17; c++) begin
      full_next = (c >= 2 && c <= 9);
      tick();
      if (c == 1) begin
        checks++; if (s_rd !== 5'b00001) begin failures++; $display("FAIL bp_c1_read: got %b expected 00001", s_rd); end
      end
      if (c >= 2 && c <= 9) begin
        checks++; if (s_rd !== 5'b0 || s_wr !== 1'b0) begin failures++; $display("FAIL bp_stall_c%0d: got rd=%b wr=%b expected rd=0 wr=0", c, s_rd, s_wr); end
      end
      if (c >= 3 && c <= 9) begin
        checks++; if (s_do !== d0 || s_gv !== 3'b000) begin failures++; $display("FAIL bp_hold_c%0d: got data=%h gv=%b expected data=%h gv=000", c, s_do, s_gv, d0); end
      end
      if (c == 10) begin
        checks++; if (s_wr !== 1'b1 || s_do !== d0) begin failures++; $display("FAIL bp_release: got wr=%b data=%h expected wr=1 data=%h", s_wr, s_do, d0); end
      end
      if (c == 11) begin
        checks++; if (s_rd !== 5'b0) begin failures++; $display("FAIL bp_c11_read: got %b expected 0", s_rd); end
      end
      if (c == 12) begin
        checks++; if (s_rd !== 5'b00001) begin failures++; $display("FAIL bp_c12_read: got %b expected 00001", s_rd); end
      end
      if (c == 14) begin
        checks++; if (s_wr !== 1'b1 || s_do !== d1) begin failures++; $display("FAIL bp_second: got wr=%b data=%h expected wr=1 data=%h", s_wr, s_do, d1); end
      end
    end
  endtask

  task automatic test_s_drop();
    logic [31:0] ds0, ds1;
    int n;
    do_reset();
    ds0 = $urandom(); ds1 = $urandom();
    bq[1].push_back(ds0);
    tick(); // cycle 0
    force_empty[1] = 1'b1;
    bq[1].push_back(ds1);
    tick(); // cycle 1
    checks++; if (s_rd !== 5'b00010 || s_gv !== 3'd1) begin failures++; $display("FAIL sdrop_grant: got rd=%b gv=%b expected rd=00010 gv=001", s_rd, s_gv); end
    for (int c = 2; c < 14; c++) begin
      tick();
      checks++; if (s_rd !== 5'b0) begin failures++; $display("FAIL sdrop_no_read_c%0d: got %b expected 0", c, s_rd); end
      if (c == 3) begin
        checks++; if (s_wr !== 1'b1 || s_do !== ds0) begin failures++; $display("FAIL sdrop_deliver: got wr=%b data=%h expected wr=1 data=%h", s_wr, s_do, ds0); end
      end
    end
    force_empty[1] = 1'b0;
    n = 0;
    do begin tick(); n++; end while (s_rd == 5'b0 && n < 12);
    checks++; if (s_rd !== 5'b00010) begin failures++; $display("FAIL sdrop_regrant: got %b expected 00010", s_rd); end
    tick();
    tick();
    checks++; if (s_wr !== 1'b1 || s_do !== ds1) begin failures++; $display("FAIL sdrop_second: got wr=%b data=%h expected wr=1 data=%h", s_wr, s_do, ds1); end
    tick();
  endtask

  // Random pushes and backpressure. The model keeps a round-robin pointer,
  // one outstanding flit and the expected flit queue; a read is due in the
  // first cycle at least two cycles after the last write whose previous cycle
  // showed a request, and a write is due from two cycles after the read on
  // every cycle the FIFO is not full.
  task automatic test_random_traffic();
    logic [31:0] exp_q [$];
    logic [31:0] exp_d;
    logic [4:0]  prev_req, exp_rd;
    logic [2:0]  exp_gv;
    logic        outs, exp_wr;
    int ref_ptr, cur_w, rd_c, last_wr, w, v;
    do_reset();
    ref_ptr = 0; outs = 1'b0; last_wr = -100; rd_c = 0; cur_w = 0; w = 0;
    prev_req = 5'b0;
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 99) < 35) begin
        v = $urandom_range(0, 4);
        if (bq[v].size() < 4) bq[v].push_back($urandom());
      end
      full_next = ($urandom_range(0, 99) < 30);
      tick();
      exp_rd = 5'b0;
      if (!outs && c >= last_wr + 2 && prev_req != 5'b0) begin
        w = arb(prev_req, ref_ptr);
        exp_rd = 5'b00001 << w;
      end
      checks++; if (s_rd !== exp_rd) begin failures++; $display("FAIL rand_read_c%0d: got %b expected %b", c, s_rd, exp_rd); end
      if (exp_rd != 5'b0) begin
        outs = 1'b1; rd_c = c; cur_w = w;
        exp_q.push_back(bq[w].size() > 0 ? bq[w][0] : 32'h0);
      end
      exp_wr = outs && (c >= rd_c + 2) && !full_next;
      checks++; if (s_wr !== exp_wr) begin failures++; $display("FAIL rand_write_c%0d: got %b expected %b", c, s_wr, exp_wr); end
      exp_gv = outs ? 3'(cur_w) : 3'b111;
      checks++; if (s_gv !== exp_gv) begin failures++; $display("FAIL rand_grant_c%0d: got %b expected %b", c, s_gv, exp_gv); end
      if (exp_wr) begin
        exp_d = exp_q.size() > 0 ? exp_q.pop_front() : 32'h0;
        checks++; if (s_do !== exp_d) begin failures++; $display("FAIL rand_data_c%0d: got %h expected %h", c, s_do, exp_d); end
        ref_ptr = (cur_w + 1) % 5;
        outs = 1'b0;
        last_wr = c;
      end
      prev_req = ~cur_empty;
    end
  endtask

  initial begin
    reset        = 1'b1;
    force_empty  = 5'b0;
    cur_empty    = 5'h1F;
    full_next    = 1'b0;
    last_rd      = 5'b0;
    cyc          = 0;
    checks       = 0;
    failures     = 0;
    for (int v = 0; v < 5; v++) vdata[v] = 32'h0;
    bus.vc_empty  = 5'h1F;
    bus.out_full  = 1'b0;
    bus.vc_data_N = 32'h0;
    bus.vc_data_S = 32'h0;
    bus.vc_data_E = 32'h0;
    bus.vc_data_W = 32'h0;
    bus.vc_data_L = 32'h0;

    test_reset();
    test_single_n();
    test_two_vc();
    test_reset_in_read();
    test_all_five();
    test_backpressure();
    test_s_drop();
    test_random_traffic();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
